// File: rtl/neuron_pkg.sv
// Shared FSM encoding and saturation helpers for the neuron datapath blocks.
package neuron_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DRAIN  = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  // All saturation maths is done in a 64-bit signed domain; callers extend into it.
  localparam int unsigned SAT_CALC_W = 64;

  function automatic logic signed [SAT_CALC_W-1:0] sat_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [SAT_CALC_W-1:0] sat_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  function automatic logic signed [SAT_CALC_W-1:0] sat_clamp(
    input logic signed [SAT_CALC_W-1:0] v,
    input int unsigned                  w
  );
    if (v > sat_max(w)) return sat_max(w);
    if (v < sat_min(w)) return sat_min(w);
    return v;
  endfunction

endpackage

// File: rtl/mac_saturate.sv
// Combinational arithmetic shift, saturation to OUT_W and optional ReLU clamp.
module mac_saturate
  import neuron_pkg::*;
#(
  parameter int unsigned ACC_W   = 20,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned SHIFT   = 0,
  parameter int unsigned RELU_EN = 1
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [OUT_W-1:0] result
);

  logic signed [ACC_W-1:0]      shifted;
  logic signed [SAT_CALC_W-1:0] clamped;

  always_comb begin
    shifted = acc >>> SHIFT;
    clamped = sat_clamp(SAT_CALC_W'(shifted), OUT_W);
    if ((RELU_EN != 0) && (clamped < 0)) begin
      clamped = '0;
    end
    result = clamped[OUT_W-1:0];
  end

endmodule

// File: rtl/neuron_mac_unit.sv
// Signed MAC neuron: bias load, N_INPUTS streamed products, saturated result out.
module neuron_mac_unit
  import neuron_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ACC_W    = 20,
  parameter int unsigned N_INPUTS = 16,
  parameter int unsigned OUT_W    = 8,
  parameter int unsigned SHIFT    = 0,
  parameter int unsigned RELU_EN  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] bias,
  input  logic                     abort,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic signed [DATA_W-1:0] in_weight,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     overflow,
  output logic                     busy
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned CNT_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

  state_t                       state;
  logic signed [ACC_W-1:0]      acc;
  logic        [CNT_W-1:0]      cnt;
  logic signed [PROD_W-1:0]     prod_r;
  logic                         prod_v;

  logic signed [ACC_W:0]        acc_sum;
  logic signed [SAT_CALC_W-1:0] acc_wide;
  logic signed [SAT_CALC_W-1:0] acc_sat;
  logic signed [ACC_W-1:0]      acc_next;
  logic                         acc_clamp;
  logic signed [OUT_W-1:0]      sat_out;

  // One guard bit is enough: ACC_W >= PROD_W, so the sum cannot wrap before clamping.
  always_comb begin
    acc_sum   = (ACC_W+1)'(acc) + (ACC_W+1)'(prod_r);
    acc_wide  = SAT_CALC_W'(acc_sum);
    acc_sat   = sat_clamp(acc_wide, ACC_W);
    acc_next  = acc_sat[ACC_W-1:0];
    acc_clamp = (acc_sat != acc_wide);
  end

  always_ff @(posedge clk) begin
    if (reset || abort) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      prod_r    <= '0;
      prod_v    <= 1'b0;
      overflow  <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (prod_v) begin
        acc <= acc_next;
        if (acc_clamp) overflow <= 1'b1;
      end
      prod_v <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc      <= ACC_W'(bias);
            cnt      <= '0;
            overflow <= 1'b0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid && in_ready) begin
            prod_r <= PROD_W'(in_data) * PROD_W'(in_weight);
            prod_v <= 1'b1;
            cnt    <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(N_INPUTS - 1)) begin
              in_ready <= 1'b0;
              state    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          out_valid <= 1'b1;
          state     <= OUTPUT;
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mac_saturate #(
    .ACC_W   (ACC_W),
    .OUT_W   (OUT_W),
    .SHIFT   (SHIFT),
    .RELU_EN (RELU_EN)
  ) u_sat (
    .acc    (acc),
    .result (sat_out)
  );

  assign out_data = out_valid ? sat_out : '0;

endmodule

// File: tb/tb_neuron_mac_unit.sv
// Directed checks of neuron_mac_unit: default, no-ReLU/shifted, and narrow-accumulator instances.
module tb_neuron_mac_unit;

  logic clk = 1'b0;
  logic reset, start, abort, in_valid, out_ready;
  logic signed [7:0] bias, in_data, in_weight;

  // a: defaults; b: RELU_EN=0, SHIFT=2; c: ACC_W=16 so the accumulator can saturate
  logic              in_ready_a, out_valid_a, overflow_a, busy_a;
  logic              in_ready_b, out_valid_b, overflow_b, busy_b;
  logic              in_ready_c, out_valid_c, overflow_c, busy_c;
  logic signed [7:0] out_data_a, out_data_b, out_data_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  neuron_mac_unit dut_a (
    .clk(clk), .reset(reset), .start(start), .bias(bias), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data), .in_weight(in_weight),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .overflow(overflow_a), .busy(busy_a)
  );

  neuron_mac_unit #(.RELU_EN(0), .SHIFT(2)) dut_b (
    .clk(clk), .reset(reset), .start(start), .bias(bias), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data), .in_weight(in_weight),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .overflow(overflow_b), .busy(busy_b)
  );

  neuron_mac_unit #(.ACC_W(16)) dut_c (
    .clk(clk), .reset(reset), .start(start), .bias(bias), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready_c), .in_data(in_data), .in_weight(in_weight),
    .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c),
    .overflow(overflow_c), .busy(busy_c)
  );

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic signed [7:0] b);
    start = 1'b1;
    bias  = b;
    tick();
    start = 1'b0;
    bias  = '0;
  endtask

  task automatic beats(input int n, input logic signed [7:0] d, input logic signed [7:0] w);
    for (int i = 0; i < n; i++) begin
      in_valid  = 1'b1;
      in_data   = d;
      in_weight = w;
      tick();
    end
    in_valid  = 1'b0;
    in_data   = '0;
    in_weight = '0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    bias = '0; in_data = '0; in_weight = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_out_valid", out_valid_a, 0);
    check("rst_out_data",  out_data_a,  0);
    check("rst_in_ready",  in_ready_a,  0);
    check("rst_busy",      busy_a,      0);
    check("rst_overflow",  overflow_a,  0);

    // 5 + 16*(2*3) = 101
    out_ready = 1'b1;
    do_start(8'sd5);
    check("t1_in_ready", in_ready_a, 1);
    check("t1_busy",     busy_a,     1);
    beats(16, 8'sd2, 8'sd3);
    check("t1_drain_valid", out_valid_a, 0);
    check("t1_drain_ready", in_ready_a,  0);
    tick();
    check("t1_valid",    out_valid_a, 1);
    check("t1_data_a",   out_data_a,  101);
    check("t1_data_b",   out_data_b,  25);
    check("t1_data_c",   out_data_c,  101);
    check("t1_overflow", overflow_a,  0);
    tick();
    check("t1_done_valid", out_valid_a, 0);
    check("t1_done_data",  out_data_a,  0);
    check("t1_done_busy",  busy_a,      0);

    // 16*(-28) = -448: ReLU -> 0, no ReLU with >>>2 -> -112
    do_start(8'sd0);
    beats(16, -8'sd4, 8'sd7);
    tick();
    check("t2_relu",   out_data_a, 0);
    check("t2_norelu", out_data_b, -112);
    check("t2_relu_c", out_data_c, 0);
    tick();

    // 127 + 16*16129 = 258191: fits 20 bits, overflows 16 bits
    do_start(8'sd127);
    beats(16, 8'sd127, 8'sd127);
    tick();
    check("t3_data_a", out_data_a, 127);
    check("t3_ovf_a",  overflow_a, 0);
    check("t3_data_b", out_data_b, 127);
    check("t3_data_c", out_data_c, 127);
    check("t3_ovf_c",  overflow_c, 1);
    tick();
    check("t3_ovf_sticky", overflow_c, 1);

    // abort mid-result after overflow, then a clean 1*1 run
    do_start(8'sd0);
    check("t5_ovf_cleared", overflow_c, 0);
    beats(7, 8'sd127, 8'sd127);
    check("t5_ovf_partial", overflow_c, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_abort_busy",  busy_a,     0);
    check("t5_abort_ready", in_ready_a, 0);
    check("t5_abort_ovf",   overflow_c, 0);
    do_start(8'sd0);
    beats(16, 8'sd1, 8'sd1);
    tick();
    check("t5_data_a", out_data_a, 16);
    check("t5_data_b", out_data_b, 4);
    check("t5_data_c", out_data_c, 16);
    check("t5_ovf_c",  overflow_c, 0);
    tick();

    // gapped input with garbage on idle beats, then 5 stalled output cycles
    out_ready = 1'b0;
    do_start(8'sd5);
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 8'sd2; in_weight = 8'sd3;
      tick();
      if (i < 15) begin
        in_valid = 1'b0; in_data = 8'sd100; in_weight = -8'sd100;
        tick();
      end
    end
    in_valid = 1'b0; in_data = '0; in_weight = '0;
    tick();
    for (int k = 0; k < 5; k++) begin
      check("t4_stall_valid", out_valid_a, 1);
      check("t4_stall_data",  out_data_a,  101);
      tick();
    end
    out_ready = 1'b1;
    check("t4_held_valid", out_valid_a, 1);
    tick();
    check("t4_taken_valid", out_valid_a, 0);

    // start with abort in IDLE: abort wins
    start = 1'b1; abort = 1'b1; bias = 8'sd9;
    tick();
    start = 1'b0; abort = 1'b0; bias = '0;
    check("sa_busy",  busy_a,     0);
    check("sa_ready", in_ready_a, 0);

    // start during ACCUM is ignored: 9 + 16*1 = 25
    do_start(8'sd9);
    beats(3, 8'sd1, 8'sd1);
    start = 1'b1; bias = 8'sd50;
    beats(1, 8'sd1, 8'sd1);
    start = 1'b0; bias = '0;
    beats(12, 8'sd1, 8'sd1);
    tick();
    check("t6_ignored_start", out_data_a, 25);
    tick();

    // reset during DRAIN
    do_start(8'sd0);
    beats(16, 8'sd1, 8'sd1);
    check("t6_drain_busy", busy_a, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_rst_valid",    out_valid_a, 0);
    check("t6_rst_data",     out_data_a,  0);
    check("t6_rst_busy",     busy_a,      0);
    check("t6_rst_ready",    in_ready_a,  0);
    check("t6_rst_overflow", overflow_a,  0);
    tick();
    check("t6_rst_valid_later", out_valid_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
